// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, RAM data_size
// encodings and the controller state type.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_t;

    // funct3[1:0] selects the access width; bit 2 only affects extension.
    function automatic logic [1:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return SIZE_BYTE;
            2'b01:   return SIZE_HALF;
            default: return SIZE_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response handshake plus RAM bus controls of the LSU.
// The tri-state data lines stay a plain inout on the unit itself.
interface lsu_if #(
    parameter int ADDR_WIDTH = 16
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [2:0]            req_funct3;
    logic [31:0]           req_address;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_error;
    logic                  bus_read;
    logic                  bus_write;
    logic [1:0]            bus_data_size;
    logic [ADDR_WIDTH-1:0] bus_address;

    modport master (
        output req_valid, req_write, req_funct3, req_address, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  bus_read, bus_write, bus_data_size, bus_address
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_address, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output bus_read, bus_write, bus_data_size, bus_address
    );

endinterface

// File: rtl/load_store_unit_load_extender.sv
// Sign/zero extension of raw RAM read data according to the load funct3.
// Kept standalone so cache fill logic can reuse it.
module load_extender
    import lsu_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_raw,
    output logic [31:0] o_data
);

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{i_raw[7]}}, i_raw[7:0]};
            F3_BU:   o_data = {24'd0, i_raw[7:0]};
            F3_H:    o_data = {{16{i_raw[15]}}, i_raw[15:0]};
            F3_HU:   o_data = {16'd0, i_raw[15:0]};
            F3_W:    o_data = i_raw;
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store bus initiator for the byte-addressed data RAM.
// Validates each request, runs one RAM access and returns a one-cycle response.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int WAIT_CYCLES = 0,
    parameter int CHECK_ALIGN = 1
) (
    input  logic  clock,
    input  logic  reset_n,
    lsu_if.slave  lsu,
    inout  wire [31:0] bus_data
);

    lsu_state_t            r_state;
    lsu_state_t            w_next;
    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata;
    logic                  r_error;
    logic [3:0]            r_count;

    logic                  w_accept;
    logic                  w_req_err;
    logic [31:0]           w_ext;
    logic                  w_ready;
    logic                  w_resp_valid;
    logic [31:0]           w_resp_rdata;
    logic                  w_resp_error;
    logic                  w_bus_read;
    logic                  w_bus_write;
    logic [1:0]            w_bus_size;
    logic [ADDR_WIDTH-1:0] w_bus_addr;

    assign w_accept = (r_state == IDLE) && lsu.req_valid;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        w_req_err = 1'b0;
        case (lsu.req_funct3)
            F3_B, F3_H, F3_W: w_req_err = 1'b0;
            F3_BU, F3_HU:     w_req_err = lsu.req_write;
            default:          w_req_err = 1'b1;
        endcase
        if ((lsu.req_address >> ADDR_WIDTH) != 32'd0)
            w_req_err = 1'b1;
        if (CHECK_ALIGN != 0) begin
            if (lsu.req_funct3[1:0] == 2'b01 && lsu.req_address[0])
                w_req_err = 1'b1;
            if (lsu.req_funct3[1:0] == 2'b10 && lsu.req_address[1:0] != 2'b00)
                w_req_err = 1'b1;
        end
    end

    // Reset asserting mid-access lands here immediately, dropping the bus strobes.
    always_ff @(posedge clock or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (lsu.req_valid) w_next = w_req_err ? RESP : ACCESS;
            ACCESS:  if (r_count == 4'd0) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_ready      = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_rdata = 32'd0;
        w_resp_error = 1'b0;
        w_bus_read   = 1'b0;
        w_bus_write  = 1'b0;
        w_bus_size   = SIZE_BYTE;
        w_bus_addr   = '0;
        case (r_state)
            IDLE: w_ready = reset_n;
            ACCESS: begin
                w_bus_addr  = r_addr;
                w_bus_size  = size_of(r_funct3);
                w_bus_write = r_write;
                w_bus_read  = !r_write;
            end
            RESP: begin
                w_resp_valid = 1'b1;
                w_resp_rdata = r_rdata;
                w_resp_error = r_error;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_write  <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_error  <= 1'b0;
            r_count  <= 4'd0;
        end else if (w_accept) begin
            r_write  <= lsu.req_write;
            r_funct3 <= lsu.req_funct3;
            r_addr   <= lsu.req_address[ADDR_WIDTH-1:0];
            r_wdata  <= lsu.req_wdata;
            r_rdata  <= 32'd0;
            r_error  <= w_req_err;
            r_count  <= 4'(WAIT_CYCLES);
        end else if (r_state == ACCESS) begin
            if (r_count != 4'd0)
                r_count <= r_count - 4'd1;
            else if (!r_write)
                r_rdata <= w_ext;
        end
    end

    load_extender u_load_extender (
        .i_funct3 (r_funct3),
        .i_raw    (bus_data),
        .o_data   (w_ext)
    );

    assign bus_data          = w_bus_write ? r_wdata : 32'bz;
    assign lsu.req_ready     = w_ready;
    assign lsu.resp_valid    = w_resp_valid;
    assign lsu.resp_rdata    = w_resp_rdata;
    assign lsu.resp_error    = w_resp_error;
    assign lsu.bus_read      = w_bus_read;
    assign lsu.bus_write     = w_bus_write;
    assign lsu.bus_data_size = w_bus_size;
    assign lsu.bus_address   = w_bus_addr;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: two instances (no wait / 3 wait cycles),
// each with a small byte RAM model on its tri-state data bus.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clock = ~clock;

    lsu_if #(.ADDR_WIDTH(16)) u_if   ();
    lsu_if #(.ADDR_WIDTH(16)) u_if_w ();
    wire [31:0] bus_data0;
    wire [31:0] bus_data1;

    load_store_unit #(.ADDR_WIDTH(16), .WAIT_CYCLES(0), .CHECK_ALIGN(1)) u_dut (
        .clock(clock), .reset_n(reset_n), .lsu(u_if), .bus_data(bus_data0)
    );

    load_store_unit #(.ADDR_WIDTH(16), .WAIT_CYCLES(3), .CHECK_ALIGN(1)) u_dut_w (
        .clock(clock), .reset_n(reset_n), .lsu(u_if_w), .bus_data(bus_data1)
    );

    // Byte RAM models (256 bytes, address bits above 7 ignored), little-endian.
    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic [7:0]  a0, a1;
    logic [31:0] rd0, rd1;

    assign a0  = u_if.bus_address[7:0];
    assign a1  = u_if_w.bus_address[7:0];
    assign rd0 = {mem0[a0 + 8'd3], mem0[a0 + 8'd2], mem0[a0 + 8'd1], mem0[a0]};
    assign rd1 = {mem1[a1 + 8'd3], mem1[a1 + 8'd2], mem1[a1 + 8'd1], mem1[a1]};
    assign bus_data0 = u_if.bus_read   ? rd0 : 32'bz;
    assign bus_data1 = u_if_w.bus_read ? rd1 : 32'bz;

    always @(posedge clock) begin
        if (u_if.bus_write) begin
            mem0[a0] <= bus_data0[7:0];
            if (u_if.bus_data_size != SIZE_BYTE) mem0[a0 + 8'd1] <= bus_data0[15:8];
            if (u_if.bus_data_size == SIZE_WORD) begin
                mem0[a0 + 8'd2] <= bus_data0[23:16];
                mem0[a0 + 8'd3] <= bus_data0[31:24];
            end
        end
        if (u_if_w.bus_write) begin
            mem1[a1] <= bus_data1[7:0];
            if (u_if_w.bus_data_size != SIZE_BYTE) mem1[a1 + 8'd1] <= bus_data1[15:8];
            if (u_if_w.bus_data_size == SIZE_WORD) begin
                mem1[a1 + 8'd2] <= bus_data1[23:16];
                mem1[a1 + 8'd3] <= bus_data1[31:24];
            end
        end
    end

    always @(negedge clock) begin
        assert (!(u_if.bus_read && u_if.bus_write)) else $error("bus_read and bus_write both high (wait 0)");
        assert (!(u_if_w.bus_read && u_if_w.bus_write)) else $error("bus_read and bus_write both high (wait 3)");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input bit sel, input logic v, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d);
        if (sel) begin
            u_if_w.req_valid = v; u_if_w.req_write = w; u_if_w.req_funct3 = f3;
            u_if_w.req_address = a; u_if_w.req_wdata = d;
        end else begin
            u_if.req_valid = v; u_if.req_write = w; u_if.req_funct3 = f3;
            u_if.req_address = a; u_if.req_wdata = d;
        end
    endtask

    // Issue one request from a negedge, then watch cycles until resp_valid.
    task automatic run_req(input bit sel, input string tag, input logic w, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output int n_wr, output int n_rd, output logic [15:0] seen_addr,
                           output logic [1:0] seen_size);
        int guard = 0;
        rdata = 32'd0; err = 1'b0; lat = 0; n_wr = 0; n_rd = 0; seen_addr = 16'd0; seen_size = 2'd0;
        @(negedge clock);
        while (!(sel ? u_if_w.req_ready : u_if.req_ready) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check({tag, "_ready_before"}, 32'(sel ? u_if_w.req_ready : u_if.req_ready), 32'd1);
        drive_req(sel, 1'b1, w, f3, a, d);
        @(negedge clock);
        drive_req(sel, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (cyc > 1) @(negedge clock);
            if (sel ? u_if_w.bus_write : u_if.bus_write) n_wr++;
            if (sel ? u_if_w.bus_read : u_if.bus_read) n_rd++;
            if (sel ? (u_if_w.bus_write || u_if_w.bus_read) : (u_if.bus_write || u_if.bus_read)) begin
                seen_addr = sel ? u_if_w.bus_address : u_if.bus_address;
                seen_size = sel ? u_if_w.bus_data_size : u_if.bus_data_size;
            end
            if (sel ? u_if_w.resp_valid : u_if.resp_valid) begin
                lat   = cyc;
                rdata = sel ? u_if_w.resp_rdata : u_if.resp_rdata;
                err   = sel ? u_if_w.resp_error : u_if.resp_error;
                break;
            end
        end
        @(negedge clock);
        check({tag, "_pulse_width"}, 32'(sel ? u_if_w.resp_valid : u_if.resp_valid), 32'd0);
        check({tag, "_ready_after"}, 32'(sel ? u_if_w.req_ready : u_if.req_ready), 32'd1);
    endtask

    task automatic do_access(input bit sel, input string tag, input logic w, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rdata,
                             input logic exp_err, input int exp_lat, input int exp_bus_cycles);
        logic [31:0] rdata;
        logic        err;
        int          lat, n_wr, n_rd;
        logic [15:0] seen_addr;
        logic [1:0]  seen_size;
        logic [1:0]  exp_size;
        run_req(sel, tag, w, f3, a, d, rdata, err, lat, n_wr, n_rd, seen_addr, seen_size);
        exp_size = (f3[1:0] == 2'b00) ? 2'b00 : (f3[1:0] == 2'b01) ? 2'b01 : 2'b11;
        check({tag, "_err"},   32'(err), 32'(exp_err));
        check({tag, "_rdata"}, rdata, exp_rdata);
        check({tag, "_lat"},   32'(lat), 32'(exp_lat));
        check({tag, "_wr_cycles"}, 32'(n_wr), (w && !exp_err) ? 32'(exp_bus_cycles) : 32'd0);
        check({tag, "_rd_cycles"}, 32'(n_rd), (!w && !exp_err) ? 32'(exp_bus_cycles) : 32'd0);
        if (!exp_err) begin
            check({tag, "_bus_addr"}, 32'(seen_addr), 32'(a[15:0]));
            check({tag, "_bus_size"}, 32'(seen_size), 32'(exp_size));
        end
    endtask

    initial begin
        int          first, second;
        logic [31:0] d1, d2;

        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive_req(1'b1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #22;
        check("rst_ready",      32'(u_if.req_ready), 32'd0);
        check("rst_resp_valid", 32'(u_if.resp_valid), 32'd0);
        check("rst_resp_error", 32'(u_if.resp_error), 32'd0);
        check("rst_resp_rdata", u_if.resp_rdata, 32'd0);
        check("rst_bus_rw",     32'({u_if.bus_read, u_if.bus_write}), 32'd0);
        check("rst_bus_size",   32'(u_if.bus_data_size), 32'd0);
        check("rst_bus_addr",   32'(u_if.bus_address), 32'd0);
        check("rst_ready_w",    32'(u_if_w.req_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 32'(u_if.req_ready), 32'd1);

        // Word, byte and half stores/loads with extension (no wait states)
        do_access(1'b0, "sw",  1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'd0,        1'b0, 2, 1);
        do_access(1'b0, "lw",  1'b0, F3_W,  32'h10, 32'd0,        32'hDEADBEEF, 1'b0, 2, 1);
        do_access(1'b0, "sb",  1'b1, F3_B,  32'h21, 32'h000000F0, 32'd0,        1'b0, 2, 1);
        do_access(1'b0, "lb",  1'b0, F3_B,  32'h21, 32'd0,        32'hFFFFFFF0, 1'b0, 2, 1);
        do_access(1'b0, "lbu", 1'b0, F3_BU, 32'h21, 32'd0,        32'h000000F0, 1'b0, 2, 1);
        do_access(1'b0, "sh",  1'b1, F3_H,  32'h30, 32'h00008001, 32'd0,        1'b0, 2, 1);
        do_access(1'b0, "lh",  1'b0, F3_H,  32'h30, 32'd0,        32'hFFFF8001, 1'b0, 2, 1);
        do_access(1'b0, "lhu", 1'b0, F3_HU, 32'h30, 32'd0,        32'h00008001, 1'b0, 2, 1);
        do_access(1'b0, "sb_hi",  1'b1, F3_B,  32'h22, 32'h12345677, 32'd0,     1'b0, 2, 1);
        do_access(1'b0, "lbu_hi", 1'b0, F3_BU, 32'h22, 32'd0,        32'h77,    1'b0, 2, 1);

        // Rejected requests: respond next cycle, no bus activity
        do_access(1'b0, "lw_misalign", 1'b0, F3_W,   32'h00002, 32'd0, 32'd0, 1'b1, 1, 0);
        do_access(1'b0, "lh_odd",      1'b0, F3_H,   32'h00031, 32'd0, 32'd0, 1'b1, 1, 0);
        do_access(1'b0, "lh_range",    1'b0, F3_H,   32'h10000, 32'd0, 32'd0, 1'b1, 1, 0);
        do_access(1'b0, "sbu_store",   1'b1, F3_BU,  32'h00010, 32'h55, 32'd0, 1'b1, 1, 0);
        do_access(1'b0, "f3_011",      1'b0, 3'b011, 32'h00010, 32'd0, 32'd0, 1'b1, 1, 0);
        do_access(1'b0, "lw_after_err", 1'b0, F3_W,  32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1);

        // Top word of the address range is legal
        do_access(1'b0, "sw_top", 1'b1, F3_W, 32'hFFFC, 32'hCAFEF00D, 32'd0,        1'b0, 2, 1);
        do_access(1'b0, "lw_top", 1'b0, F3_W, 32'hFFFC, 32'd0,        32'hCAFEF00D, 1'b0, 2, 1);

        // Reset pulsed during the ACCESS cycle of a store aborts it
        do_access(1'b0, "sw_40", 1'b1, F3_W, 32'h40, 32'h11223344, 32'd0, 1'b0, 2, 1);
        @(negedge clock);
        drive_req(1'b0, 1'b1, 1'b1, F3_W, 32'h40, 32'hAAAAAAAA);
        @(posedge clock);
        #2;
        check("abort_pre_write", 32'(u_if.bus_write), 32'd1);
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        reset_n = 1'b0;
        #1;
        check("abort_write_drop", 32'(u_if.bus_write), 32'd0);
        check("abort_ready_low",  32'(u_if.req_ready), 32'd0);
        check("abort_no_resp",    32'(u_if.resp_valid), 32'd0);
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(negedge clock);
        check("abort_ready_after", 32'(u_if.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("abort_resp_quiet", 32'(u_if.resp_valid), 32'd0);
            @(negedge clock);
        end
        do_access(1'b0, "lw_40", 1'b0, F3_W, 32'h40, 32'd0, 32'h11223344, 1'b0, 2, 1);

        // req_valid held high across two requests
        first = 0; second = 0; d1 = 32'd0; d2 = 32'd0;
        @(negedge clock);
        drive_req(1'b0, 1'b1, 1'b0, F3_W, 32'h10, 32'd0);
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            if (u_if.resp_valid) begin
                if (first == 0) begin
                    first = cyc; d1 = u_if.resp_rdata;
                end else begin
                    second = cyc; d2 = u_if.resp_rdata;
                end
            end
            if (second != 0) break;
            if (first != 0 && u_if.req_ready)
                drive_req(1'b0, 1'b1, 1'b0, F3_HU, 32'h30, 32'd0);
        end
        drive_req(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check("b2b_first_lat",   32'(first),  32'd2);
        check("b2b_first_data",  d1,          32'hDEADBEEF);
        check("b2b_second_lat",  32'(second), 32'd5);
        check("b2b_second_data", d2,          32'h00008001);

        // Three wait states: bus strobe held 4 cycles, response at acceptance+5
        do_access(1'b1, "w_sw", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'd0,        1'b0, 5, 4);
        do_access(1'b1, "w_lw", 1'b0, F3_W, 32'h10, 32'd0,        32'hDEADBEEF, 1'b0, 5, 4);
        do_access(1'b1, "w_lb", 1'b0, F3_B, 32'h13, 32'd0,        32'hFFFFFFDE, 1'b0, 5, 4);
        do_access(1'b1, "w_err", 1'b0, F3_W, 32'h11, 32'd0,       32'd0,        1'b1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Bus initiator for the byte-addressed data RAM: accepts one load/store request at a time from the core and drives address, read, write and data_size.
- Owns the shared 32-bit tri-state data bus during stores.
- Returns sign- or zero-extended load data, or an error, through a one-cycle response.
- Sits between the execute stage and the RAM.

Parameters:
- ADDR_WIDTH, 16, width of the RAM byte address; request addresses at or above 2**ADDR_WIDTH are errors.
- WAIT_CYCLES, 0, extra ACCESS cycles held before load sampling or store commit (0..15).
- CHECK_ALIGN, 1, 1 = reject misaligned half/word accesses; 0 = pass them to the bus.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle and able to accept.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_address  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_error  out  1  qualifies resp_valid; 1 = misaligned, out of range, or illegal funct3.
- bus_read  out  1  RAM read enable.
- bus_write  out  1  RAM write enable.
- bus_data_size  out  2  00 byte, 01 half, 11 word; 10 never driven.
- bus_address  out  ADDR_WIDTH  RAM byte address.
- bus_data  inout  32  driven only while bus_write=1, else high-Z.

Behaviour:
- Reset (async, reset_n=0):
  - State IDLE, counter 0.
  - req_ready=0 while reset_n=0, 1 from the first cycle after release.
  - resp_valid=0, resp_error=0, resp_rdata=0.
  - bus_read=0, bus_write=0, bus_data_size=00, bus_address=0, bus_data=Z.
  - Reset mid-ACCESS aborts the access: bus_write drops immediately and no response is issued.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at a clock edge, latch the request and validate it.
  - Validation error if any of the following holds:
    - funct3 is not in {000,001,010,100,101};
    - req_write=1 with funct3 100 or 101;
    - req_address[31:ADDR_WIDTH] is nonzero;
    - CHECK_ALIGN=1 and (half with address[0]=1, or word with address[1:0]!=0).
  - Error -> RESP with resp_error=1 and no bus activity. Otherwise -> ACCESS with counter=WAIT_CYCLES.
- ACCESS:
  - req_ready=0.
  - Drive bus_address = latched address[ADDR_WIDTH-1:0], bus_data_size from funct3[1:0] (00->00, 01->01, 10->11).
  - Store: bus_write=1, bus_data=wdata.
  - Load: bus_read=1, bus_data=Z.
  - bus_read and bus_write are never both 1.
  - Counter decrements each cycle. In the cycle where counter=0:
    - Load: capture bus_data at the edge.
    - Store: the RAM commits on that edge.
  - Then -> RESP.
- Store data: no lane shifting; the RAM consumes the low bytes at the address.
- Load extension, on captured bus_data:
  - B: sign-extend [7:0]. BU: zero-extend [7:0].
  - H: sign-extend [15:0]. HU: zero-extend [15:0].
  - W: pass [31:0].
- RESP:
  - resp_valid=1 for exactly one cycle with resp_rdata/resp_error.
  - All bus controls are 0 and bus_data is Z.
  - Then -> IDLE.
- Latency: request accepted at edge N; ACCESS occupies cycles N+1 .. N+1+WAIT_CYCLES; resp_valid in the following cycle. With WAIT_CYCLES=0 a valid load/store takes 3 cycles from acceptance to IDLE. An error request responds in the cycle after acceptance.
- Back-to-back: a new request is accepted only in IDLE, so there is one idle cycle between responses. req_valid outside IDLE is ignored; the requester holds it until it sees req_ready.
- Word access at the top address of the range is legal; no wrap check beyond alignment.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - bus data_size encodings (SIZE_BYTE=00, SIZE_HALF=01, SIZE_WORD=11);
  - state enum lsu_state_t {IDLE, ACCESS, RESP}.
- One combinational sub-module, load_extender (funct3, raw 32-bit -> extended 32-bit), is shared with future cache fill logic.

Test Plan:
- Store SW addr 0x0010 data 0xDEADBEEF, then LW 0x0010 -> resp_rdata=0xDEADBEEF, resp_error=0; the bus shows data_size=11 and write high for exactly one cycle.
- SB 0x0021 data 0x000000F0, then LB 0x0021 -> 0xFFFFFFF0 and LBU -> 0x000000F0; SH 0x0030 data 0x8001, then LH -> 0xFFFF8001 and LHU -> 0x00008001.
- LW 0x0002 with CHECK_ALIGN=1 -> resp_error=1 one cycle after acceptance, bus_read/bus_write never asserted; LH 0x10000 (ADDR_WIDTH=16) -> error; store with funct3 100 -> error.
- WAIT_CYCLES=3: SW then LW -> bus_write held 4 cycles, resp_valid at acceptance+5, data correct; bus_data is Z except during the store.
- reset_n pulsed low during ACCESS of SW 0x0040 -> bus_write and bus_data release immediately, no resp_valid, req_ready=1 the cycle after release; LW 0x0040 returns the prior contents.
- req_valid held high across two requests -> second accepted only after resp_valid; bus_read and bus_write never both 1 in any cycle (assertion).
